// File: rtl/scr1_dmem_tcm_pkg.sv
// Shared types and defaults for the data TCM responder: memory-interface enums,
// responder FSM states and the request-legality helper.
package scr1_dmem_tcm_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    CAP  = 3'd2,
    WAIT = 3'd3,
    RSP  = 3'd4,
    ERR  = 3'd5
  } type_scr1_dmem_tcm_fsm_e;

  localparam logic [31:0] SCR1_TCM_BASE_DEFAULT      = 32'h0048_0000;
  localparam int          SCR1_TCM_SIZE_LOG2_DEFAULT = 14;

  // Unknown width encodings are treated as misaligned so they fault like any other bad access.
  function automatic logic scr1_dmem_misaligned(input type_scr1_mem_width_e width,
                                                input logic [1:0] offset);
    logic bad;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  bad = 1'b0;
      SCR1_MEM_WIDTH_HWORD: bad = offset[0];
      SCR1_MEM_WIDTH_WORD:  bad = |offset;
      default:              bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/scr1_dmem_lane_align.sv
// Byte-lane steering between a right-justified memory request and a 32-bit SRAM word.
// Purely combinational so the IMEM TCM port can reuse it unchanged.
module scr1_dmem_lane_align
  import scr1_dmem_tcm_pkg::*;
(
  input  type_scr1_mem_width_e width,
  input  logic [1:0]           offset,
  input  logic [31:0]          wdata,
  input  logic [31:0]          ram_rdata,
  output logic [3:0]           be,
  output logic [31:0]          wdata_sh,
  output logic [31:0]          rdata_rj
);

  logic [31:0] rdata_sh_s;

  assign wdata_sh   = wdata << {offset, 3'b000};
  assign rdata_sh_s = ram_rdata >> {offset, 3'b000};

  // Byte enables and zero-filled read data per access width.
  always_comb begin
    be       = 4'b0000;
    rdata_rj = 32'h0000_0000;
    case (width)
      SCR1_MEM_WIDTH_BYTE: begin
        be       = 4'b0001 << offset;
        rdata_rj = {24'h00_0000, rdata_sh_s[7:0]};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        be       = 4'b0011 << offset;
        rdata_rj = {16'h0000, rdata_sh_s[15:0]};
      end
      SCR1_MEM_WIDTH_WORD: begin
        be       = 4'b1111;
        rdata_rj = rdata_sh_s;
      end
      default: begin
        be       = 4'b0000;
        rdata_rj = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/scr1_dmem_tcm_resp.sv
// DMEM target for the core-local data TCM: one request at a time, range/alignment
// checking, single-port synchronous SRAM with 1-cycle read latency.
module scr1_dmem_tcm_resp
  import scr1_dmem_tcm_pkg::*;
#(
  parameter int                          SCR1_DMEM_AWIDTH = 32,
  parameter int                          SCR1_DMEM_DWIDTH = 32,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_BASE         = SCR1_TCM_BASE_DEFAULT,
  parameter int                          TCM_SIZE_LOG2    = SCR1_TCM_SIZE_LOG2_DEFAULT,
  parameter int                          WAIT_STATES      = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  output logic                          dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic [3:0]                    ram_be,
  output logic [TCM_SIZE_LOG2-3:0]      ram_addr,
  output logic [31:0]                   ram_wdata,
  input  logic [31:0]                   ram_rdata
);

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  type_scr1_dmem_tcm_fsm_e state_r;
  type_scr1_dmem_tcm_fsm_e state_next_s;
  type_scr1_mem_cmd_e      cmd_r;
  type_scr1_mem_width_e    width_r;
  logic [TCM_SIZE_LOG2-1:0] addr_r;
  logic [31:0]             wdata_r;
  logic [31:0]             rdata_r;
  logic [2:0]              wait_cnt_r;

  logic                    accept_s;
  logic                    fault_s;
  logic [3:0]              lane_be_s;
  logic [31:0]             lane_wdata_s;
  logic [31:0]             lane_rdata_s;

  assign dmem_req_ack = (state_r == IDLE);
  assign accept_s     = dmem_req & dmem_req_ack;
  assign fault_s      = (dmem_addr[SCR1_DMEM_AWIDTH-1:TCM_SIZE_LOG2] !=
                         TCM_BASE[SCR1_DMEM_AWIDTH-1:TCM_SIZE_LOG2])
                      | scr1_dmem_misaligned(dmem_width, dmem_addr[1:0]);
  assign ram_addr     = addr_r[TCM_SIZE_LOG2-1:2];

  scr1_dmem_lane_align u_lane_align (
    .width     (width_r),
    .offset    (addr_r[1:0]),
    .wdata     (wdata_r),
    .ram_rdata (ram_rdata),
    .be        (lane_be_s),
    .wdata_sh  (lane_wdata_s),
    .rdata_rj  (lane_rdata_s)
  );

  // Next-state logic of the access sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = fault_s ? ERR : ACC;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACC: state_next_s = CAP;
      CAP: begin
        if (WAIT_STATES > 0) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = RSP;
        end
      end
      WAIT: begin
        if (wait_cnt_r == 3'd0) begin
          state_next_s = RSP;
        end else begin
          state_next_s = WAIT;
        end
      end
      RSP:     state_next_s = IDLE;
      ERR:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request fields are latched only at acceptance and held through the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r   <= SCR1_MEM_CMD_RD;
      width_r <= SCR1_MEM_WIDTH_BYTE;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      cmd_r   <= dmem_cmd;
      width_r <= dmem_width;
      addr_r  <= dmem_addr[TCM_SIZE_LOG2-1:0];
      wdata_r <= dmem_wdata;
    end
  end

  // SRAM data is sampled in CAP unconditionally; write responses simply ignore it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (state_r == CAP) begin
      rdata_r <= lane_rdata_s;
    end
  end

  // Wait-state down-counter, armed on the way out of CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 3'd0;
    end else if (state_r == CAP) begin
      wait_cnt_r <= WAIT_LOAD;
    end else if ((state_r == WAIT) && (wait_cnt_r != 3'd0)) begin
      wait_cnt_r <= wait_cnt_r - 3'd1;
    end
  end

  // Outputs decoded from registered state only, so a reset drops them immediately.
  always_comb begin
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_be     = 4'b0000;
    ram_wdata  = 32'h0000_0000;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    case (state_r)
      ACC: begin
        ram_cs = 1'b1;
        if (cmd_r == SCR1_MEM_CMD_WR) begin
          ram_we    = 1'b1;
          ram_be    = lane_be_s;
          ram_wdata = lane_wdata_s;
        end else begin
          ram_we    = 1'b0;
          ram_be    = 4'b0000;
          ram_wdata = 32'h0000_0000;
        end
      end
      RSP: begin
        dmem_resp = SCR1_MEM_RESP_RDY_OK;
        if (cmd_r == SCR1_MEM_CMD_RD) begin
          dmem_rdata = rdata_r;
        end else begin
          dmem_rdata = '0;
        end
      end
      ERR: begin
        dmem_resp  = SCR1_MEM_RESP_RDY_ER;
        dmem_rdata = '0;
      end
      default: begin
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = '0;
      end
    endcase
  end

endmodule

// File: doc/scr1_dmem_tcm_resp.md
Name: scr1_dmem_tcm_resp

Overview:
- Data-memory responder: the target end of the DMEM req/ack/resp interface that the load/store unit initiates on.
- Accepts one request at a time, checks range and alignment, and drives a single-port synchronous SRAM (1-cycle read latency) with byte enables.
- Returns right-justified read data with RDY_OK, or RDY_ER on fault.
- Sits between the pipeline's DMEM port and the core-local data TCM.

Parameters:
- SCR1_DMEM_AWIDTH, 32, request address width.
- SCR1_DMEM_DWIDTH, 32, data width (fixed 4 byte lanes).
- TCM_BASE, 32'h0048_0000, TCM base address, aligned to 2**TCM_SIZE_LOG2.
- TCM_SIZE_LOG2, 14, TCM size in bytes, log2 (16 KiB).
- WAIT_STATES, 0, extra cycles inserted before the response; legal range 0..7.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- dmem_req  in  1  request valid; held by the initiator until acked.
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR.
- dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD.
- dmem_addr  in  SCR1_DMEM_AWIDTH  byte address.
- dmem_wdata  in  SCR1_DMEM_DWIDTH  store data, right-justified.
- dmem_req_ack  out  1  request accepted this cycle.
- dmem_rdata  out  SCR1_DMEM_DWIDTH  load data, right-justified, upper bytes zero.
- dmem_resp  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER.
- ram_cs  out  1  SRAM select.
- ram_we  out  1  SRAM write enable.
- ram_be  out  4  SRAM byte enables.
- ram_addr  out  TCM_SIZE_LOG2-2  SRAM word address.
- ram_wdata  out  32  lane-positioned write data.
- ram_rdata  in  32  SRAM read data, valid the cycle after a read select.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: state IDLE; dmem_resp=NOTRDY; dmem_rdata=0; ram_cs=0; ram_we=0; ram_be=0; all latched request fields 0.
- dmem_req_ack = (state==IDLE), combinational. It is high out of reset.
- Acceptance: dmem_req & dmem_req_ack sampled at a posedge (cycle N). At that edge, latch cmd, width, addr and wdata, and evaluate the fault conditions.
- Fault conditions (evaluated at acceptance): any one of these faults the request.
  - Address out of range: addr[AW-1:TCM_SIZE_LOG2] != TCM_BASE[AW-1:TCM_SIZE_LOG2].
  - HWORD with addr[0]=1.
  - WORD with addr[1:0]!=0.
  - Width encoding not BYTE, HWORD or WORD.
- State machine:
  - IDLE -> on accept: ERR if faulted, else ACC.
  - ACC (cycle N+1): ram_cs=1, ram_we=(cmd==WR), ram_addr=addr[TCM_SIZE_LOG2-1:2]. Then -> CAP.
  - CAP (cycle N+2): register ram_rdata >> (8*addr[1:0]). The ram_rdata capture also occurs for writes but is discarded. Then WAIT if WAIT_STATES>0, else RSP.
  - WAIT: 3-bit counter loaded with WAIT_STATES-1 on entry and decremented each cycle; -> RSP when it reaches 0.
  - RSP (cycle N+3+WAIT_STATES): dmem_resp=RDY_OK for exactly one cycle, then -> IDLE.
  - ERR (cycle N+1): dmem_resp=RDY_ER, dmem_rdata=0 for one cycle, then -> IDLE. No SRAM access for a faulted request.
- Write lanes:
  - BYTE: be = 4'b0001<<addr[1:0].
  - HWORD: be = 4'b0011<<addr[1:0].
  - WORD: be = 4'b1111.
  - ram_wdata = wdata << 8*addr[1:0].
  - ram_be=0 on reads. ram_be and ram_wdata are meaningful only in ACC.
- Read data:
  - BYTE: dmem_rdata[7:0] valid, [31:8]=0.
  - HWORD: dmem_rdata[15:0] valid, [31:16]=0.
  - Sign extension is the initiator's job.
  - dmem_rdata=0 in every cycle other than RSP, and 0 for a write response.
- dmem_resp is NOTRDY in all states except RSP and ERR, so at most one response per accepted request.
- Requests arriving in non-IDLE states are not acked. The initiator holds them, and they are accepted on the next IDLE cycle.
- Back-to-back: acceptance is possible in the cycle after RSP/ERR, giving a minimum request pitch of 4+WAIT_STATES cycles (OK) and 2 cycles (ERR).
- Reset mid-operation: state returns to IDLE asynchronously; ram_cs drops immediately; no response is issued for the aborted request.
- dmem_req deasserted while not acked: no effect.

Decomposition:
- Package scr1_dmem_tcm_pkg holds:
  - FSM enum type_scr1_dmem_tcm_fsm_e {IDLE, ACC, CAP, WAIT, RSP, ERR};
  - default TCM_BASE and TCM_SIZE_LOG2 constants.
- Memory command, width and response enums are reused from the existing memory interface header.
- One combinational sub-module, scr1_dmem_lane_align (width, offset, wdata, ram_rdata -> be, shifted wdata, right-justified rdata), shared with the future IMEM TCM port.

Test Plan:
1. Reset, then WORD WR addr=TCM_BASE+0x10 wdata=32'hDEADBEEF -> ack in cycle 0; ACC cycle: ram_cs=1, we=1, be=4'b1111, ram_addr=0x4; RDY_OK in cycle 3 (WAIT_STATES=0).
2. SRAM word 0x4 = 32'h11223344; BYTE RD addr offset +0x13 -> ram_be=0; RDY_OK with dmem_rdata=32'h0000_0011; HWORD RD offset +0x12 -> 32'h0000_1122.
3. HWORD WR offset +0x2, wdata=32'h0000_ABCD -> be=4'b1100, ram_wdata=32'hABCD_0000.
4. WORD RD addr=TCM_BASE+0x2 (misaligned), and separately addr=TCM_BASE+0x4000 (out of range) -> RDY_ER in cycle 1, ram_cs never asserted, rdata=0.
5. WAIT_STATES=3 build, back-to-back RD with req held -> second request not acked until the cycle after RSP; RDY_OK in cycle 6 after each accept.
6. rst_n asserted during ACC of a WR -> ram_cs drops asynchronously; no dmem_resp; after release ack=1, and the next request completes normally.
